spi_sram_target: RTL and testbench

SPI_SRAM_TARGET -- requirements
Module: spi_sram_target

---
 rtl/spi_sram_target.sv | 197 +++++++++++++++++++
 tb/tb_spi_sram_target.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sram_target.sv
// SPI mode-0 target bridging SRAM-style READ (0x03) / WRITE (0x02) commands onto a byte-wide memory port.
// Optional mode register (0x05 read, 0x01 write) enabled by defining SPI_SRAM_TARGET_MODE_REG_EN.
module spi_sram_target #(
    parameter int unsigned CLK_RATIO_MIN = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_clk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, READ, WRITE, MODE_RD, MODE_WR, IGNORE
    } state_t;

    if (CLK_RATIO_MIN == 0) begin : g_ratio_doc
    end

    state_t      state_q, state_d;
    logic [1:0]  sck_sync, cs_sync, mosi_sync;
    logic        sck_d, cs_d;
    logic [1:0]  settle_q;
    logic        armed_q;
    logic [3:0]  cnt_q;
    logic [7:0]  shift_q;
    logic [7:0]  tx_q;
    logic [15:0] addr_q;
    logic [15:0] addr_inc;
    logic        is_read_q;
    logic        rd_pend_q;
    logic        miso_q;
`ifdef SPI_SRAM_TARGET_MODE_REG_EN
    logic [7:0]  mode_q;
`endif

    logic       mosi_s, sck_rise, sck_fall, cs_fall, cs_rise, byte_done;
    logic [7:0] rx_byte;

    assign mosi_s    = mosi_sync[1];
    assign sck_rise  = sck_sync[1] & ~sck_d;
    assign sck_fall  = ~sck_sync[1] & sck_d;
    assign cs_rise   = cs_sync[1] & ~cs_d;
    // A fall only counts once cs_n has been seen high after reset, so a
    // transaction already in flight at reset release is ignored.
    assign cs_fall   = ~cs_sync[1] & cs_d & armed_q;
    assign byte_done = sck_rise && (cnt_q[2:0] == 3'd7);
    assign rx_byte   = {shift_q[6:0], mosi_s};

    assign spi_miso_oe = (state_q == READ) || (state_q == MODE_RD);
    assign spi_miso    = miso_q & spi_miso_oe;

    always_comb begin
        addr_inc = addr_q + 16'd1;
`ifdef SPI_SRAM_TARGET_MODE_REG_EN
        case (mode_q[7:6])
            2'b00:   addr_inc = addr_q;
            2'b10:   addr_inc = {addr_q[15:5], addr_q[4:0] + 5'd1};
            default: ;
        endcase
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            cs_d      <= 1'b1;
            settle_q  <= '0;
            armed_q   <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[0], spi_clk};
            cs_sync   <= {cs_sync[0], spi_cs_n};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            sck_d     <= sck_sync[1];
            cs_d      <= cs_sync[1];
            if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
            if (settle_q == 2'd3 && cs_sync[1]) armed_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (cs_fall) state_d = CMD;
                CMD: if (byte_done) begin
                    case (rx_byte)
                        8'h02, 8'h03: state_d = ADDR;
`ifdef SPI_SRAM_TARGET_MODE_REG_EN
                        8'h05:        state_d = MODE_RD;
                        8'h01:        state_d = MODE_WR;
`endif
                        default:      state_d = IGNORE;
                    endcase
                end
                ADDR: if (sck_rise && cnt_q == 4'd15) state_d = is_read_q ? READ : WRITE;
                MODE_WR: if (byte_done) state_d = IGNORE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            shift_q   <= '0;
            tx_q      <= '0;
            addr_q    <= '0;
            is_read_q <= 1'b0;
            rd_pend_q <= 1'b0;
            miso_q    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
`ifdef SPI_SRAM_TARGET_MODE_REG_EN
            mode_q    <= 8'h40;
`endif
        end else begin
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            rd_pend_q <= mem_re;

            if (sck_fall) begin
                if (spi_miso_oe) begin
                    miso_q <= tx_q[7];
                    tx_q   <= {tx_q[6:0], 1'b0};
                end else begin
                    miso_q <= 1'b0;
                end
            end

            // Read data lands in the tx register ahead of the byte's first fall.
            if (rd_pend_q) tx_q <= mem_rdata;

            if (sck_rise && !cs_rise) begin
                shift_q <= rx_byte;
                if (state_q != ADDR && cnt_q[2:0] == 3'd7) cnt_q <= '0;
                else                                       cnt_q <= cnt_q + 4'd1;
                case (state_q)
                    CMD: if (byte_done) begin
                        is_read_q <= (rx_byte == 8'h03);
`ifdef SPI_SRAM_TARGET_MODE_REG_EN
                        tx_q      <= mode_q;
`endif
                    end
                    ADDR: begin
                        addr_q <= {addr_q[14:0], mosi_s};
                        if (cnt_q == 4'd15 && is_read_q) begin
                            mem_re   <= 1'b1;
                            mem_addr <= {addr_q[14:0], mosi_s};
                        end
                    end
                    READ: if (byte_done) begin
                        addr_q   <= addr_inc;
                        mem_re   <= 1'b1;
                        mem_addr <= addr_inc;
                    end
                    WRITE: if (byte_done) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= addr_q;
                        mem_wdata <= rx_byte;
                        addr_q    <= addr_inc;
                    end
`ifdef SPI_SRAM_TARGET_MODE_REG_EN
                    MODE_RD: if (byte_done) tx_q <= mode_q;
                    MODE_WR: if (byte_done) mode_q <= rx_byte;
`endif
                    default: ;
                endcase
            end

            if (cs_rise || state_q == IDLE) begin
                cnt_q  <= '0;
                miso_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_sram_target.sv
// Self-checking bench for spi_sram_target: directed command cases plus random read/write
// transactions against a byte-array reference model. Mode-register cases follow SPI_SRAM_TARGET_MODE_REG_EN.
module tb_spi_sram_target;

    localparam int HALF = 8;

    logic        clk, rst_n, spi_clk, spi_cs_n, spi_mosi;
    logic        spi_miso, spi_miso_oe, mem_we, mem_re;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    spi_sram_target #(.CLK_RATIO_MIN(8)) dut (
        .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] store   [65536];
    logic [7:0] ref_mem [65536];
    logic [7:0] mode_m;

    always @(posedge clk) begin
        if (mem_we) store[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= store[mem_addr];
    end

    logic [15:0] we_addr_q[$];
    logic [7:0]  we_data_q[$];
    logic [15:0] re_addr_q[$];
    logic        oe_seen;
    int          both_cnt, miso_bad;

    always @(negedge clk) begin
        if (mem_we) begin
            we_addr_q.push_back(mem_addr);
            we_data_q.push_back(mem_wdata);
        end
        if (mem_re) re_addr_q.push_back(mem_addr);
        if (mem_we && mem_re) both_cnt++;
        if (spi_miso_oe) oe_seen = 1'b1;
        if (!spi_miso_oe && spi_miso) miso_bad++;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_next(input logic [15:0] a);
        int ai;
        ai = int'(a);
        case (mode_m[7:6])
            2'b00:   return a;
            2'b10:   return 16'((ai / 32) * 32 + ((ai % 32) + 1) % 32);
            default: return 16'((ai + 1) % 65536);
        endcase
    endfunction

    task automatic half_wait();
        repeat (HALF) @(negedge clk);
    endtask

    task automatic clear_mon();
        we_addr_q.delete();
        we_data_q.delete();
        re_addr_q.delete();
        oe_seen = 1'b0;
    endtask

    task automatic spi_begin();
        spi_cs_n = 1'b0;
        half_wait();
    endtask

    task automatic spi_end();
        half_wait();
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (4) half_wait();
    endtask

    task automatic spi_bits(input logic [31:0] d, input int n, output logic [31:0] rx);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = d[i];
            half_wait();
            rx = {rx[30:0], spi_miso};
            spi_clk = 1'b1;
            half_wait();
            spi_clk = 1'b0;
        end
    endtask

    task automatic do_write(input logic [15:0] a, input int n, input logic [31:0] d);
        logic [31:0] rx;
        logic [15:0] ea;
        logic [7:0]  b;
        clear_mon();
        spi_begin();
        spi_bits(32'h02, 8, rx);
        spi_bits({16'h0, a}, 16, rx);
        for (int i = 0; i < n; i++) spi_bits({24'h0, d[8*(3-i) +: 8]}, 8, rx);
        spi_end();
        check("wr_we_count", we_addr_q.size(), n);
        check("wr_re_count", re_addr_q.size(), 0);
        check("wr_oe", {31'h0, oe_seen}, 0);
        ea = a;
        for (int i = 0; i < n; i++) begin
            b = d[8*(3-i) +: 8];
            if (i < we_addr_q.size()) begin
                check("wr_addr", we_addr_q[i], ea);
                check("wr_data", we_data_q[i], b);
            end
            ref_mem[ea] = b;
            ea = model_next(ea);
        end
    endtask

    task automatic do_read(input logic [15:0] a, input int n);
        logic [31:0] rx;
        logic [7:0]  got[4];
        logic [15:0] ea;
        clear_mon();
        spi_begin();
        spi_bits(32'h03, 8, rx);
        spi_bits({16'h0, a}, 16, rx);
        for (int i = 0; i < n; i++) begin
            spi_bits(32'h0, 8, rx);
            got[i] = rx[7:0];
        end
        spi_end();
        check("rd_re_count", re_addr_q.size(), n + 1);
        check("rd_we_count", we_addr_q.size(), 0);
        check("rd_oe", {31'h0, oe_seen}, 1);
        ea = a;
        for (int i = 0; i <= n; i++) begin
            if (i < re_addr_q.size()) check("rd_addr", re_addr_q[i], ea);
            if (i < n) check("rd_data", got[i], ref_mem[ea]);
            ea = model_next(ea);
        end
    endtask

    task automatic no_strobe_checks(input string tag, input logic exp_oe);
        check({tag, "_we"}, we_addr_q.size(), 0);
        check({tag, "_re"}, re_addr_q.size(), 0);
        check({tag, "_oe"}, {31'h0, oe_seen}, {31'h0, exp_oe});
    endtask

    initial begin
        logic [31:0] rx;
        logic [7:0]  v;
        rst_n = 1'b0; spi_clk = 1'b0; spi_cs_n = 1'b0; spi_mosi = 1'b0;
        both_cnt = 0; miso_bad = 0; oe_seen = 1'b0; mode_m = 8'h40;
        for (int i = 0; i < 65536; i++) begin
            v = 8'($urandom);
            store[i] = v;
            ref_mem[i] = v;
        end

        repeat (5) @(negedge clk);
        check("rst_miso", {31'h0, spi_miso}, 0);
        check("rst_oe", {31'h0, spi_miso_oe}, 0);
        check("rst_we", {31'h0, mem_we}, 0);
        check("rst_re", {31'h0, mem_re}, 0);
        check("rst_addr", {16'h0, mem_addr}, 0);
        check("rst_wdata", {24'h0, mem_wdata}, 0);

        // Reset released mid-transaction: the whole transfer must be ignored.
        rst_n = 1'b1;
        clear_mon();
        spi_bits(32'h02_0030_AA, 32, rx);
        spi_end();
        no_strobe_checks("rst_midtx", 1'b0);

        do_write(16'h0010, 2, 32'hAABB_0000);
        do_read(16'h0010, 2);
        check("rd_aa_const", {24'h0, ref_mem[16'h0010]}, 32'hAA);
        do_read(16'hFFFF, 2);

        // Partial trailing byte is dropped.
        clear_mon();
        spi_begin();
        spi_bits(32'h02, 8, rx);
        spi_bits(32'h0020, 16, rx);
        spi_bits(32'hABC, 12, rx);
        spi_end();
        check("part_we_count", we_addr_q.size(), 1);
        if (we_addr_q.size() > 0) begin
            check("part_addr", we_addr_q[0], 16'h0020);
            check("part_data", we_data_q[0], 8'hAB);
        end
        ref_mem[16'h0020] = 8'hAB;
        do_read(16'h0020, 1);

        clear_mon();
        spi_begin();
        spi_bits(32'h9F, 8, rx);
        spi_bits(32'h5A5A, 16, rx);
        spi_end();
        no_strobe_checks("unk_cmd", 1'b0);

`ifdef SPI_SRAM_TARGET_MODE_REG_EN
        clear_mon();
        spi_begin();
        spi_bits(32'h01, 8, rx);
        spi_bits(32'h00, 8, rx);
        spi_bits(32'hFF, 8, rx);
        spi_end();
        no_strobe_checks("mode_wr", 1'b0);
        mode_m = 8'h00;
        do_read(16'h0005, 2);
        clear_mon();
        spi_begin();
        spi_bits(32'h05, 8, rx);
        spi_bits(32'h0, 8, rx);
        check("mode_rd0", rx, {24'h0, mode_m});
        spi_bits(32'h0, 8, rx);
        check("mode_rd1", rx, {24'h0, mode_m});
        spi_end();
        no_strobe_checks("mode_rd", 1'b1);

        clear_mon();
        spi_begin();
        spi_bits(32'h01, 8, rx);
        spi_bits(32'h80, 8, rx);
        spi_end();
        mode_m = 8'h80;
        do_write(16'h003E, 3, 32'h1122_3300);
        do_read(16'h003F, 2);

        clear_mon();
        spi_begin();
        spi_bits(32'h01, 8, rx);
        spi_bits(32'h40, 8, rx);
        spi_end();
        mode_m = 8'h40;
`else
        clear_mon();
        spi_begin();
        spi_bits(32'h05, 8, rx);
        spi_bits(32'h0, 16, rx);
        spi_end();
        no_strobe_checks("no_mode_rd", 1'b0);
        clear_mon();
        spi_begin();
        spi_bits(32'h01, 8, rx);
        spi_bits(32'h00, 8, rx);
        spi_end();
        no_strobe_checks("no_mode_wr", 1'b0);
        do_read(16'h0005, 2);
`endif

        for (int t = 0; t < 16; t++) begin
            logic [15:0] a;
            int          n;
            a = ($urandom_range(0, 3) == 0) ? (16'hFFFC | 16'($urandom_range(0, 3))) : 16'($urandom);
            n = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 0) do_write(a, n, $urandom);
            else                           do_read(a, n);
        end

        check("we_re_overlap", both_cnt, 0);
        check("miso_without_oe", miso_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
